// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
//   Multi-cycle shift-add multiplier for the EX stage. When a valid MUL
//   instruction reaches EX, it stalls the pipeline for DATA_WIDTH+1 cycles.
//   During that time it adds the shifted multiplicand once per multiplier bit.
//   It then pulses Mul_Done with the low DATA_WIDTH bits of the product.
//
// Ports
//   CLK         core clock, rising edge
//   RST         asynchronous reset, active-high
//   ALUControl  decoded ALU operation of the instruction in EX
//   Op_Valid    EX holds a valid, non-bubble instruction
//   Flush       EX is being killed; aborts or blocks a multiply
//   SrcA        multiplicand
//   SrcB        multiplier
//   Mul_Stall   hold IF/ID/EX pipeline registers
//   Mul_Done    one-cycle pulse, Mul_Result valid
//   Mul_Result  low DATA_WIDTH bits of SrcA*SrcB, held until the next done
// ---------------------------------------------------------------------------
module mul_sequencer #(
   parameter int                           DATA_WIDTH        = 32,
   parameter int                           ALU_Control_width = 3,
   parameter logic [ALU_Control_width-1:0] MUL_CODE          = 3'b101,
   parameter int                           CNT_WIDTH         = 6
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [ALU_Control_width-1:0] ALUControl,
   input  logic                         Op_Valid,
   input  logic                         Flush,
   input  logic [DATA_WIDTH-1:0]        SrcA,
   input  logic [DATA_WIDTH-1:0]        SrcB,
   output logic                         Mul_Stall,
   output logic                         Mul_Done,
   output logic [DATA_WIDTH-1:0]        Mul_Result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [CNT_WIDTH-1:0]  count;
   logic [DATA_WIDTH-1:0] acc_next;
   logic                  start;

   // Gating with RST keeps every output low while reset is held, even if a
   // MUL is presented in EX at that moment.
   assign start = ~RST & (state == IDLE) & Op_Valid &
                  (ALUControl == MUL_CODE) & ~Flush;

   // The stall must rise in the same cycle the MUL reaches EX.
   // It must also drop in the same cycle as a flush, so it is combinational.
   assign Mul_Stall = start | ((state == BUSY) & ~Flush);

   // A flush during DONE kills the instruction, so its done pulse is dropped.
   assign Mul_Done = (state == DONE) & ~Flush;

   // One shift-add step; wraps modulo 2^DATA_WIDTH, identical for signed.
   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         count      <= '0;
         Mul_Result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= SrcA;
                  mplier <= SrcB;
                  acc    <= '0;
                  count  <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (Flush) begin
                  state <= IDLE;
               end else begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 1'b1;
                  // Fixed latency: no early exit when the multiplier runs out.
                  if (count == LAST) begin
                     Mul_Result <= acc_next;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               // The stalled MUL leaves EX this cycle, so it cannot retrigger.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
